key_debounce_multi: RTL and testbench

Parameterised, multi-channel successor to the single-key debouncer. Filters KEY_NUM active-low mechanical keys independently. Per key it produces:
- a debounced level;
- one-cycle press and release pulses;
- a stretched press flag for slow consumers;
- a long-press pulse.

Sits between the board key pins and the music-player control logic (play/pause, next, volume).

---
 rtl/key_debounce_multi_if.sv | 32 +++
 rtl/key_debounce_multi.sv | 215 +++++++++++++++++++++
 tb/tb_key_debounce_multi.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_multi_if.sv
// Key-pin / debouncer bundle: raw active-low keys in, filtered per-key events out.
// The key-pin side (board or bench) uses master; the debouncer uses slave.
interface key_debounce_multi_if #(
  parameter int unsigned KEY_NUM = 4
) ();

  logic [KEY_NUM-1:0] key;
  logic [KEY_NUM-1:0] key_level;
  logic [KEY_NUM-1:0] key_press;
  logic [KEY_NUM-1:0] key_release;
  logic [KEY_NUM-1:0] key_flag_hold;
  logic [KEY_NUM-1:0] key_long;

  modport master (
    output key,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_flag_hold,
    input  key_long
  );

  modport slave (
    input  key,
    output key_level,
    output key_press,
    output key_release,
    output key_flag_hold,
    output key_long
  );

endinterface

// File: rtl/key_debounce_multi.sv
// Multi-channel debouncer for active-low keys: level, press/release/long pulses and a
// stretched press flag per key. Define KEY_REPEAT_EN to add auto-repeat after a long press.
module key_debounce_multi #(
  parameter int unsigned KEY_NUM    = 4,
  parameter int unsigned CNT_MAX    = 1_000_000,
  parameter int unsigned FLAG_HOLD  = 150_000,
  parameter int unsigned LONG_MAX   = 50_000_000,
  parameter int unsigned REPEAT_MAX = 10_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  key_debounce_multi_if.slave bus_io
);

  localparam int unsigned CntW  = $clog2(CNT_MAX);
  localparam int unsigned FlagW = $clog2(FLAG_HOLD);
  localparam int unsigned HoldW = $clog2(LONG_MAX);

  localparam logic [CntW-1:0]  CntLast  = CntW'(CNT_MAX - 1);
  localparam logic [FlagW-1:0] FlagLast = FlagW'(FLAG_HOLD - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_MAX - 1);
  localparam logic [HoldW-1:0] HoldPre  = HoldW'(LONG_MAX - 2);

  typedef enum logic [1:0] {
    StIdle,
    StPressChk,
    StPressed,
    StReleaseChk
  } state_e;

  // Synchroniser presets to released so a key held through reset needs a full debounce.
  logic [KEY_NUM-1:0] sync1_q;
  logic [KEY_NUM-1:0] key_s_q;

  state_e             state_q    [KEY_NUM];
  state_e             state_d    [KEY_NUM];
  logic [CntW-1:0]    cnt_q      [KEY_NUM];
  logic [CntW-1:0]    cnt_d      [KEY_NUM];
  logic [HoldW-1:0]   hold_q     [KEY_NUM];
  logic [HoldW-1:0]   hold_d     [KEY_NUM];
  logic [FlagW-1:0]   flag_cnt_q [KEY_NUM];
  logic [FlagW-1:0]   flag_cnt_d [KEY_NUM];

  logic [KEY_NUM-1:0] level_q, level_d;
  logic [KEY_NUM-1:0] press_q, press_d;
  logic [KEY_NUM-1:0] release_q, release_d;
  logic [KEY_NUM-1:0] flag_q, flag_d;
  logic [KEY_NUM-1:0] long_q, long_d;

`ifdef KEY_REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_MAX);
  localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_MAX - 1);

  logic [RepW-1:0]    rep_cnt_q [KEY_NUM];
  logic [RepW-1:0]    rep_cnt_d [KEY_NUM];
  logic [KEY_NUM-1:0] rep_en_q, rep_en_d;
`else
  logic unused_repeat_max;
  assign unused_repeat_max = (REPEAT_MAX != 0);
`endif

  always_comb begin
    for (int i = 0; i < KEY_NUM; i++) begin
      state_d[i]    = state_q[i];
      cnt_d[i]      = cnt_q[i];
      hold_d[i]     = hold_q[i];
      flag_cnt_d[i] = flag_cnt_q[i];
      level_d[i]    = level_q[i];
      flag_d[i]     = flag_q[i];
      press_d[i]    = 1'b0;
      release_d[i]  = 1'b0;
      long_d[i]     = 1'b0;

      unique case (state_q[i])
        StIdle: begin
          if (!key_s_q[i]) begin
            state_d[i] = StPressChk;
            cnt_d[i]   = '0;
          end
        end
        StPressChk: begin
          if (key_s_q[i]) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StPressed;
            cnt_d[i]   = '0;
            hold_d[i]  = '0;
            press_d[i] = 1'b1;
            level_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        StPressed: begin
          if (key_s_q[i]) begin
            state_d[i] = StReleaseChk;
            cnt_d[i]   = '0;
          end
        end
        StReleaseChk: begin
          if (!key_s_q[i]) begin
            state_d[i] = StPressed;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i]   = StIdle;
            cnt_d[i]     = '0;
            hold_d[i]    = '0;
            release_d[i] = 1'b1;
            level_d[i]   = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = StIdle;
          cnt_d[i]   = '0;
        end
      endcase

      // Hold time keeps running through release bounces; saturation limits key_long to once.
      if ((state_q[i] == StPressed || state_q[i] == StReleaseChk) && !release_d[i] &&
          hold_q[i] != HoldLast) begin
        hold_d[i] = hold_q[i] + 1'b1;
        long_d[i] = (hold_q[i] == HoldPre);
      end

`ifdef KEY_REPEAT_EN
      rep_en_d[i]  = rep_en_q[i];
      rep_cnt_d[i] = rep_cnt_q[i];
      if (release_d[i]) begin
        rep_en_d[i]  = 1'b0;
        rep_cnt_d[i] = '0;
      end else if (long_d[i]) begin
        rep_en_d[i]  = 1'b1;
        rep_cnt_d[i] = '0;
      end else if (rep_en_q[i]) begin
        if (rep_cnt_q[i] == RepLast) begin
          rep_cnt_d[i] = '0;
          press_d[i]   = 1'b1;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
        end
      end
`endif

      // Flag follows the registered press, so a fresh press restarts it without a gap.
      if (press_q[i]) begin
        flag_d[i]     = 1'b1;
        flag_cnt_d[i] = '0;
      end else if (flag_q[i]) begin
        if (flag_cnt_q[i] == FlagLast) begin
          flag_d[i] = 1'b0;
        end else begin
          flag_cnt_d[i] = flag_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q   <= '1;
      key_s_q   <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      flag_q    <= '0;
      long_q    <= '0;
      for (int i = 0; i < KEY_NUM; i++) begin
        state_q[i]    <= StIdle;
        cnt_q[i]      <= '0;
        hold_q[i]     <= '0;
        flag_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= bus_io.key;
      key_s_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      flag_q    <= flag_d;
      long_q    <= long_d;
      for (int i = 0; i < KEY_NUM; i++) begin
        state_q[i]    <= state_d[i];
        cnt_q[i]      <= cnt_d[i];
        hold_q[i]     <= hold_d[i];
        flag_cnt_q[i] <= flag_cnt_d[i];
      end
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rep_en_q <= '0;
      for (int i = 0; i < KEY_NUM; i++) begin
        rep_cnt_q[i] <= '0;
      end
    end else begin
      rep_en_q <= rep_en_d;
      for (int i = 0; i < KEY_NUM; i++) begin
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
    end
  end
`endif

  assign bus_io.key_level     = level_q;
  assign bus_io.key_press     = press_q;
  assign bus_io.key_release   = release_q;
  assign bus_io.key_flag_hold = flag_q;
  assign bus_io.key_long      = long_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: event times logged each cycle, checked against
// hand-computed cycle offsets from the driving edge.
module tb_key_debounce_multi;

  localparam int unsigned KeyNum    = 2;
  localparam int unsigned CntMax    = 8;
  localparam int unsigned FlagHold  = 5;
  localparam int unsigned LongMax   = 20;
  localparam int unsigned RepeatMax = 6;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  key_debounce_multi_if #(.KEY_NUM(KeyNum)) bus_if ();

  key_debounce_multi #(
    .KEY_NUM   (KeyNum),
    .CNT_MAX   (CntMax),
    .FLAG_HOLD (FlagHold),
    .LONG_MAX  (LongMax),
    .REPEAT_MAX(RepeatMax)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus_io   (bus_if)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int press_n      [KeyNum];
  int press_at     [KeyNum];
  int release_n    [KeyNum];
  int release_at   [KeyNum];
  int long_n       [KeyNum];
  int long_at      [KeyNum];
  int lvl_rise_at  [KeyNum];
  int lvl_fall_at  [KeyNum];
  int flag_rise_at [KeyNum];
  int flag_fall_at [KeyNum];
  int press_log0   [$];

  logic [KeyNum-1:0] lvl_prev  = '0;
  logic [KeyNum-1:0] flag_prev = '0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    for (int ch = 0; ch < KeyNum; ch++) begin
      press_n[ch]      = 0;
      press_at[ch]     = -1;
      release_n[ch]    = 0;
      release_at[ch]   = -1;
      long_n[ch]       = 0;
      long_at[ch]      = -1;
      lvl_rise_at[ch]  = -1;
      lvl_fall_at[ch]  = -1;
      flag_rise_at[ch] = -1;
      flag_fall_at[ch] = -1;
    end
    press_log0.delete();
  endtask

  // Sample on the falling edge, away from the registers' active edge.
  task automatic tick();
    @(negedge sys_clk);
    cyc++;
    for (int ch = 0; ch < KeyNum; ch++) begin
      if (bus_if.key_press[ch]) begin
        press_n[ch]++;
        press_at[ch] = cyc;
        if (ch == 0) press_log0.push_back(cyc);
      end
      if (bus_if.key_release[ch]) begin
        release_n[ch]++;
        release_at[ch] = cyc;
      end
      if (bus_if.key_long[ch]) begin
        long_n[ch]++;
        long_at[ch] = cyc;
      end
      if (bus_if.key_level[ch] && !lvl_prev[ch]) lvl_rise_at[ch] = cyc;
      if (!bus_if.key_level[ch] && lvl_prev[ch]) lvl_fall_at[ch] = cyc;
      if (bus_if.key_flag_hold[ch] && !flag_prev[ch]) flag_rise_at[ch] = cyc;
      if (!bus_if.key_flag_hold[ch] && flag_prev[ch]) flag_fall_at[ch] = cyc;
    end
    lvl_prev  = bus_if.key_level;
    flag_prev = bus_if.key_flag_hold;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int fall;
    int rise;
    int p;
    int l;
    int exp_press [$];

    // 1: key[0] held low through reset
    bus_if.key = 2'b10;
    clear_log();
    ticks(3);
    check_eq("rst_level", int'(bus_if.key_level), 0);
    check_eq("rst_press", int'(bus_if.key_press), 0);
    check_eq("rst_flag", int'(bus_if.key_flag_hold), 0);
    check_eq("rst_long_release", int'(bus_if.key_long) + int'(bus_if.key_release), 0);

    clear_log();
    sys_rst_n = 1'b1;
    fall = cyc + 1;
    ticks(10);
    check_eq("t1_no_early_press", press_n[0], 0);
    ticks(2);
    check_eq("t1_press_count", press_n[0], 1);
    check_eq("t1_press_at", press_at[0], fall + 10);
    check_eq("t1_level_rise", lvl_rise_at[0], fall + 10);

    // 3: clean release, plus stretched flag from the press above
    bus_if.key[0] = 1'b1;
    rise = cyc + 1;
    ticks(12);
    check_eq("t3_release_count", release_n[0], 1);
    check_eq("t3_release_at", release_at[0], rise + 10);
    check_eq("t3_level_fall", lvl_fall_at[0], rise + 10);
    check_eq("t3_flag_rise", flag_rise_at[0], fall + 11);
    check_eq("t3_flag_fall", flag_fall_at[0], fall + 16);
    check_eq("t3_no_long", long_n[0], 0);

    // 2: bounce then steady press
    clear_log();
    bus_if.key[0] = 1'b0;
    ticks(5);
    bus_if.key[0] = 1'b1;
    ticks(1);
    bus_if.key[0] = 1'b0;
    fall = cyc + 1;
    ticks(12);
    check_eq("t2_press_count", press_n[0], 1);
    check_eq("t2_press_at", press_at[0], fall + 10);
    bus_if.key[0] = 1'b1;
    rise = cyc + 1;
    ticks(12);
    check_eq("t2_release_at", release_at[0], rise + 10);

    // 4: long press on key[1] with a 3-cycle release glitch
    clear_log();
    bus_if.key[1] = 1'b0;
    fall = cyc + 1;
    ticks(11);
    p = fall + 10;
    check_eq("t4_press_at", press_at[1], p);
    ticks(12);
    bus_if.key[1] = 1'b1;
    ticks(3);
    bus_if.key[1] = 1'b0;
    ticks(25);
    check_eq("t4_no_glitch_release", release_n[1], 0);
    check_eq("t4_level_held", lvl_fall_at[1], -1);
    check_eq("t4_long_count", long_n[1], 1);
    check_eq("t4_long_at", long_at[1], p + 19);
    bus_if.key[1] = 1'b1;
    rise = cyc + 1;
    ticks(12);
    check_eq("t4_release_at", release_at[1], rise + 10);
    check_eq("t4_long_once", long_n[1], 1);

    // 5: simultaneous press and release on both channels
    clear_log();
    bus_if.key = 2'b00;
    fall = cyc + 1;
    ticks(12);
    check_eq("t5_press0_at", press_at[0], fall + 10);
    check_eq("t5_press1_at", press_at[1], fall + 10);
    check_eq("t5_press_counts", press_n[0] + press_n[1], 2);
    bus_if.key = 2'b11;
    rise = cyc + 1;
    ticks(12);
    check_eq("t5_release0_at", release_at[0], rise + 10);
    check_eq("t5_release1_at", release_at[1], rise + 10);

    // 6: hold key[0] past long press, release, watch for repeats
    clear_log();
    bus_if.key[0] = 1'b0;
    fall = cyc + 1;
    ticks(11);
    p = fall + 10;
    ticks(19);
    l = p + 19;
    check_eq("t6_long_at", long_at[0], l);
    ticks(18);
    bus_if.key[0] = 1'b1;
    ticks(30);
    check_eq("t6_release_at", release_at[0], l + 29);
    exp_press.push_back(p);
`ifdef KEY_REPEAT_EN
    exp_press.push_back(l + 6);
    exp_press.push_back(l + 12);
    exp_press.push_back(l + 18);
    exp_press.push_back(l + 24);
    check_eq("t6_flag_retrigger", flag_rise_at[0], l + 25);
`else
    check_eq("t6_flag_retrigger", flag_rise_at[0], p + 1);
`endif
    check_eq("t6_press_count", press_log0.size(), exp_press.size());
    for (int i = 0; i < exp_press.size() && i < press_log0.size(); i++) begin
      check_eq($sformatf("t6_press%0d_at", i), press_log0[i], exp_press[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
